// File: rtl/pll_reconfig_pkg.sv
// rtl/pll_reconfig_pkg.sv - shared constants, state encoding and divider field encoder for the PLL reconfig master
package pll_reconfig_pkg;

    localparam int unsigned ADDR_MODE   = 0;
    localparam int unsigned ADDR_STATUS = 1;
    localparam int unsigned ADDR_START  = 2;
    localparam int unsigned ADDR_N      = 3;
    localparam int unsigned ADDR_M      = 4;
    localparam int unsigned ADDR_C      = 5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ZERO    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_WR_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_C,
        S_WR_START,
        S_WAIT_LOCK,
        S_DONE,
        S_ERR
    } state_t;

    // [17] odd, [16] bypass, [15:8] high count, [7:0] low count; d=1 bypasses the counter
    function automatic logic [17:0] encode_div(input logic [7:0] d);
        logic [17:0] f;
        f = '0;
        if (d == 8'd1) begin
            f[16] = 1'b1;
        end else begin
            f[15:8] = (d >> 1) + {7'd0, d[0]};
            f[7:0]  = d >> 1;
            f[17]   = d[0];
        end
        return f;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - pll_locked synchronizer and consecutive-lock qualifier
module pll_lock_sync #(
    parameter int LOCK_STABLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic pll_locked,
    output logic lock_stable
);

    localparam int SW = $clog2(LOCK_STABLE + 1);

    logic          sync1;
    logic          sync2;
    logic [SW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1 <= pll_locked;
            sync2 <= sync1;
            // Any low sample restarts the run; the count parks at the threshold
            if (clear || !sync2) begin
                stable_cnt <= '0;
            end else if (stable_cnt != SW'(LOCK_STABLE)) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign lock_stable = (stable_cnt == SW'(LOCK_STABLE));

endmodule

// File: rtl/pll_reconfig_master.sv
// rtl/pll_reconfig_master.sv - Avalon-MM master that reprograms N/M/C0 and waits for PLL re-lock
module pll_reconfig_master
    import pll_reconfig_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 100000,
    parameter int LOCK_STABLE  = 16,
    parameter int C_INDEX      = 0,
    parameter int ADDR_W       = 6
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        n_div,
    input  logic [7:0]        m_mul,
    input  logic [7:0]        c_div,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] mgmt_address,
    output logic [31:0]       mgmt_writedata,
    output logic              mgmt_write,
    output logic              mgmt_read,
    input  logic              mgmt_waitrequest,
    input  logic              pll_locked
);

    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    state_t        state;
    state_t        state_next;
    logic [7:0]    n_q;
    logic [7:0]    m_q;
    logic [7:0]    c_q;
    logic [TW-1:0] timeout_cnt;
    logic          lock_stable;
    logic          timeout_hit;
    logic          any_zero;

    pll_lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_lock_sync (
        .clk        (refclk),
        .rst        (rst),
        .clear      (state != S_WAIT_LOCK),
        .pll_locked (pll_locked),
        .lock_stable(lock_stable)
    );

    assign any_zero    = (n_q == 8'd0) || (m_q == 8'd0) || (c_q == 8'd0);
    // Fires on the cycle whose increment brings the count up to LOCK_TIMEOUT
    assign timeout_hit = (timeout_cnt >= TW'(LOCK_TIMEOUT - 1));
    assign mgmt_read   = 1'b0;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_IDLE;
            err_code    <= ERR_NONE;
            n_q         <= '0;
            m_q         <= '0;
            c_q         <= '0;
            timeout_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && start) begin
                n_q      <= n_div;
                m_q      <= m_mul;
                c_q      <= c_div;
                err_code <= ERR_NONE;
            end
            if (state == S_CHECK && any_zero) begin
                err_code <= ERR_ZERO;
            end
            if (state == S_WAIT_LOCK && !lock_stable && timeout_hit) begin
                err_code <= ERR_TIMEOUT;
            end
            if (state != S_WAIT_LOCK) begin
                timeout_cnt <= '0;
            end else if (timeout_cnt != TW'(LOCK_TIMEOUT)) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        busy           = 1'b1;
        done           = 1'b0;
        err            = 1'b0;
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_CHECK;
            end
            S_CHECK: state_next = any_zero ? S_ERR : S_WR_MODE;
            S_WR_MODE: begin
                mgmt_write   = 1'b1;
                mgmt_address = ADDR_W'(ADDR_MODE);
                if (!mgmt_waitrequest) state_next = S_WR_N;
            end
            S_WR_N: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_W'(ADDR_N);
                mgmt_writedata = {14'd0, encode_div(n_q)};
                if (!mgmt_waitrequest) state_next = S_WR_M;
            end
            S_WR_M: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_W'(ADDR_M);
                mgmt_writedata = {14'd0, encode_div(m_q)};
                if (!mgmt_waitrequest) state_next = S_WR_C;
            end
            S_WR_C: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_W'(ADDR_C);
                mgmt_writedata = {9'd0, 5'(C_INDEX), encode_div(c_q)};
                if (!mgmt_waitrequest) state_next = S_WR_START;
            end
            S_WR_START: begin
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_W'(ADDR_START);
                mgmt_writedata = 32'd1;
                if (!mgmt_waitrequest) state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_stable)      state_next = S_DONE;
                else if (timeout_hit) state_next = S_ERR;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_ERR: begin
                err        = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pll_reconfig_master.sv
// tb/tb_pll_reconfig_master.sv - directed self-checking bench for pll_reconfig_master
module tb_pll_reconfig_master;

    localparam int LT = 200;
    localparam int LS = 16;
    localparam int CI = 3;
    localparam int AW = 6;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    n_div = 8'd0;
    logic [7:0]    m_mul = 8'd0;
    logic [7:0]    c_div = 8'd0;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW-1:0] mgmt_address;
    logic [31:0]   mgmt_writedata;
    logic          mgmt_write;
    logic          mgmt_read;
    logic          mgmt_waitrequest = 1'b0;
    logic          pll_locked = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    int err_cyc = 0;
    int start_cyc = 0;
    int acc_start_cyc = 0;
    int start_writes = 0;
    int rise_cyc = 0;
    int any_write = 0;
    int unstable = 0;
    logic [37:0] wr_q[$];
    int          wr_cyc_q[$];
    bit          pend = 1'b0;
    logic [37:0] pend_word = '0;
    bit          prev_locked = 1'b0;

    bit slave_rand = 1'b0;
    bit stall_on_m = 1'b0;
    int stall = 0;
    bit prev_write = 1'b0;

    pll_reconfig_master #(
        .LOCK_TIMEOUT(LT),
        .LOCK_STABLE (LS),
        .C_INDEX     (CI),
        .ADDR_W      (AW)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .start           (start),
        .n_div           (n_div),
        .m_mul           (m_mul),
        .c_div           (c_div),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .err_code        (err_code),
        .mgmt_address    (mgmt_address),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_write      (mgmt_write),
        .mgmt_read       (mgmt_read),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked      (pll_locked)
    );

    always #5 refclk = ~refclk;

    // Bus and pulse observer; inputs only change just after posedge, so the negedge view is what the DUT samples
    always @(negedge refclk) begin
        cyc = cyc + 1;
        if (start) start_cyc = cyc;
        if (done) begin done_cnt += 1; done_cyc = cyc; end
        if (err) begin err_cnt += 1; err_cyc = cyc; end
        if (mgmt_write) any_write += 1;
        if (pll_locked && !prev_locked) rise_cyc = cyc;
        prev_locked = pll_locked;
        if (pend && (!mgmt_write || {mgmt_address, mgmt_writedata} != pend_word)) unstable += 1;
        pend = mgmt_write && mgmt_waitrequest && !rst;
        pend_word = {mgmt_address, mgmt_writedata};
        if (mgmt_write && !mgmt_waitrequest && !rst) begin
            wr_q.push_back({mgmt_address, mgmt_writedata});
            wr_cyc_q.push_back(cyc);
            if (mgmt_address == 6'd2) begin
                acc_start_cyc = cyc;
                start_writes += 1;
            end
        end
    end

    // Reconfig slave: optional random stall per write, or hold the M write indefinitely
    initial begin
        forever begin
            @(posedge refclk); #1;
            if (!mgmt_write) begin
                stall = 0;
                mgmt_waitrequest = 1'b0;
            end else if (prev_write && mgmt_waitrequest) begin
                if (stall > 0) stall -= 1;
                mgmt_waitrequest = (stall > 0);
            end else begin
                stall = slave_rand ? int'($urandom_range(0, 3)) : 0;
                mgmt_waitrequest = (stall > 0);
            end
            if (stall_on_m && mgmt_write && mgmt_address == 6'd4) mgmt_waitrequest = 1'b1;
            prev_write = mgmt_write;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge refclk); #1; end
    endtask

    task automatic issue(input logic [7:0] n, input logic [7:0] m, input logic [7:0] c);
        n_div = n; m_mul = m; c_div = c;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_end(input int base, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (done_cnt + err_cnt > base) begin timed_out = 1'b0; break; end
            tick(1);
        end
    endtask

    task automatic wait_start_write(input int base, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (start_writes > base) begin timed_out = 1'b0; break; end
            tick(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        vectors++;
        if ({busy, done, err, err_code, mgmt_write, mgmt_read} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got busy/done/err/code/wr/rd=%b want 0000000", {busy, done, err, err_code, mgmt_write, mgmt_read});
        end
        vectors++;
        if ({mgmt_address, mgmt_writedata} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_bus: got addr=%h data=%h want 0/0", mgmt_address, mgmt_writedata);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        logic [37:0] exp_w[5];
        int base, ds, sw;
        bit to;
        exp_w[0] = {6'd0, 32'h0000_0000};
        exp_w[1] = {6'd3, 32'h0001_0000};
        exp_w[2] = {6'd4, 32'h0000_0101};
        exp_w[3] = {6'd5, 32'h000C_0101};
        exp_w[4] = {6'd2, 32'h0000_0001};
        wr_q.delete(); wr_cyc_q.delete();
        base = done_cnt + err_cnt; ds = done_cnt; sw = start_writes;
        issue(8'd1, 8'd2, 8'd2);
        wait_start_write(sw, to);
        tick(20);
        pll_locked = 1'b1;
        wait_end(base, to);
        vectors++;
        if (to || done_cnt != ds + 1) begin
            miscompares++;
            $display("FAIL basic_done: got timeout=%0d done_pulses=%0d want 0/1", to, done_cnt - ds);
        end
        vectors++;
        if (err_code !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_err_code: got %b want 00", err_code);
        end
        vectors++;
        if (wr_q.size() != 5) begin
            miscompares++;
            $display("FAIL basic_write_count: got %0d want 5", wr_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (wr_q[i] !== exp_w[i]) begin
                    miscompares++;
                    $display("FAIL basic_write%0d: got addr=%h data=%h want addr=%h data=%h", i, wr_q[i][37:32], wr_q[i][31:0], exp_w[i][37:32], exp_w[i][31:0]);
                end
            end
            vectors++;
            if (wr_cyc_q[4] - wr_cyc_q[0] != 4) begin
                miscompares++;
                $display("FAIL basic_back_to_back: got span=%0d cycles want 4", wr_cyc_q[4] - wr_cyc_q[0]);
            end
        end
        vectors++;
        if (done_cyc - rise_cyc < LS + 2 || done_cyc - rise_cyc > LS + 6) begin
            miscompares++;
            $display("FAIL basic_lock_latency: got %0d want %0d..%0d", done_cyc - rise_cyc, LS + 2, LS + 6);
        end
        pll_locked = 1'b0;
        tick(5);
    endtask

    task automatic test_wait_random();
        logic [37:0] exp_w[5];
        int base, ds, sw;
        bit to;
        exp_w[0] = {6'd0, 32'h0000_0000};
        exp_w[1] = {6'd3, 32'h0002_807F};
        exp_w[2] = {6'd4, 32'h0002_0302};
        exp_w[3] = {6'd5, 32'h000E_0403};
        exp_w[4] = {6'd2, 32'h0000_0001};
        wr_q.delete(); wr_cyc_q.delete();
        unstable = 0; slave_rand = 1'b1;
        base = done_cnt + err_cnt; ds = done_cnt; sw = start_writes;
        issue(8'd255, 8'd5, 8'd7);
        wait_start_write(sw, to);
        pll_locked = 1'b1;
        wait_end(base, to);
        slave_rand = 1'b0;
        vectors++;
        if (to || done_cnt != ds + 1) begin
            miscompares++;
            $display("FAIL wait_done: got timeout=%0d done_pulses=%0d want 0/1", to, done_cnt - ds);
        end
        vectors++;
        if (unstable != 0) begin
            miscompares++;
            $display("FAIL wait_stable: got %0d changes under waitrequest want 0", unstable);
        end
        vectors++;
        if (wr_q.size() != 5) begin
            miscompares++;
            $display("FAIL wait_write_count: got %0d want 5", wr_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (wr_q[i] !== exp_w[i]) begin
                    miscompares++;
                    $display("FAIL wait_write%0d: got addr=%h data=%h want addr=%h data=%h", i, wr_q[i][37:32], wr_q[i][31:0], exp_w[i][37:32], exp_w[i][31:0]);
                end
            end
        end
        pll_locked = 1'b0;
        tick(5);
    endtask

    task automatic test_zero_div();
        int base, ds, aw;
        bit to;
        base = done_cnt + err_cnt; ds = done_cnt; aw = any_write;
        issue(8'd4, 8'd4, 8'd0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_busy: got %b want 1", busy);
        end
        wait_end(base, to);
        tick(2);
        vectors++;
        if (to || err_cyc - start_cyc != 2) begin
            miscompares++;
            $display("FAIL zero_err_latency: got timeout=%0d latency=%0d want 0/2", to, err_cyc - start_cyc);
        end
        vectors++;
        if (err_code !== 2'b01) begin
            miscompares++;
            $display("FAIL zero_err_code: got %b want 01", err_code);
        end
        vectors++;
        if (any_write != aw || done_cnt != ds) begin
            miscompares++;
            $display("FAIL zero_no_bus: got write_cycles=%0d done_pulses=%0d want 0/0", any_write - aw, done_cnt - ds);
        end
    endtask

    task automatic test_timeout();
        int base, ds;
        bit to;
        base = done_cnt + err_cnt; ds = done_cnt;
        pll_locked = 1'b0;
        issue(8'd2, 8'd2, 8'd2);
        wait_end(base, to);
        tick(5);
        vectors++;
        if (to || done_cnt != ds) begin
            miscompares++;
            $display("FAIL timeout_err: got timeout=%0d done_pulses=%0d want 0/0", to, done_cnt - ds);
        end
        vectors++;
        if (err_cyc - acc_start_cyc < LT || err_cyc - acc_start_cyc > LT + 2) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d want %0d..%0d", err_cyc - acc_start_cyc, LT, LT + 2);
        end
        vectors++;
        if (err_code !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_err_code: got %b want 10", err_code);
        end
    endtask

    task automatic test_lock_toggle();
        int base, ds, es, sw;
        bit to;
        base = done_cnt + err_cnt; ds = done_cnt; es = err_cnt; sw = start_writes;
        issue(8'd2, 8'd3, 8'd4);
        wait_start_write(sw, to);
        for (int i = 0; i < 10; i++) begin
            tick(8);
            pll_locked = ~pll_locked;
        end
        vectors++;
        if (done_cnt != ds || err_cnt != es) begin
            miscompares++;
            $display("FAIL toggle_early: got done=%0d err=%0d while toggling want 0/0", done_cnt - ds, err_cnt - es);
        end
        pll_locked = 1'b1;
        wait_end(base, to);
        vectors++;
        if (to || done_cnt != ds + 1) begin
            miscompares++;
            $display("FAIL toggle_done: got timeout=%0d done_pulses=%0d want 0/1", to, done_cnt - ds);
        end
        vectors++;
        if (done_cyc - rise_cyc < LS + 2 || done_cyc - rise_cyc > LS + 6) begin
            miscompares++;
            $display("FAIL toggle_latency: got %0d want %0d..%0d", done_cyc - rise_cyc, LS + 2, LS + 6);
        end
        vectors++;
        if (err_code !== 2'b00) begin
            miscompares++;
            $display("FAIL toggle_err_code: got %b want 00", err_code);
        end
        pll_locked = 1'b0;
        tick(5);
    endtask

    task automatic test_reset_mid();
        logic [37:0] exp_w[5];
        int base, ds;
        bit to;
        bit reached;
        exp_w[0] = {6'd0, 32'h0000_0000};
        exp_w[1] = {6'd3, 32'h0002_0201};
        exp_w[2] = {6'd4, 32'h0000_0202};
        exp_w[3] = {6'd5, 32'h000E_0302};
        exp_w[4] = {6'd2, 32'h0000_0001};
        stall_on_m = 1'b1;
        issue(8'd3, 8'd4, 8'd5);
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mgmt_write && mgmt_address == 6'd4) begin reached = 1'b1; break; end
            tick(1);
        end
        tick(2);
        vectors++;
        if (!reached || !mgmt_waitrequest) begin
            miscompares++;
            $display("FAIL rst_mid_reach: got reached=%0d waitrequest=%b want 1/1", reached, mgmt_waitrequest);
        end
        rst = 1'b1;
        tick(1);
        vectors++;
        if (mgmt_write !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_drop: got write=%b busy=%b want 0/0", mgmt_write, busy);
        end
        rst = 1'b0;
        stall_on_m = 1'b0;
        wr_q.delete(); wr_cyc_q.delete();
        tick(1);
        base = done_cnt + err_cnt; ds = done_cnt;
        pll_locked = 1'b1;
        issue(8'd3, 8'd4, 8'd5);
        wait_end(base, to);
        vectors++;
        if (to || done_cnt != ds + 1) begin
            miscompares++;
            $display("FAIL rst_mid_restart_done: got timeout=%0d done_pulses=%0d want 0/1", to, done_cnt - ds);
        end
        vectors++;
        if (wr_q.size() != 5) begin
            miscompares++;
            $display("FAIL rst_mid_write_count: got %0d want 5", wr_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (wr_q[i] !== exp_w[i]) begin
                    miscompares++;
                    $display("FAIL rst_mid_write%0d: got addr=%h data=%h want addr=%h data=%h", i, wr_q[i][37:32], wr_q[i][31:0], exp_w[i][37:32], exp_w[i][31:0]);
                end
            end
        end
        pll_locked = 1'b0;
        tick(5);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_random();
        test_zero_div();
        test_timeout();
        test_lock_toggle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
